// File: rtl/nand2_check_if.sv
// nand2_check_if: stimulus/response bundle between a NAND test bench driver
// (master) and the nand2_check response monitor (slave).
//   start      : one-cycle request to begin a check run
//   A, B       : stimulus vector {A,B} (A is the MSB)
//   Y          : output of the gate under check
//   busy, done, pass, timeout, mismatch : run status
//   err_cnt    : saturating failing-sample count
//   seen       : coverage bitmap indexed by {A,B}
//   first_fail : {A,B} of the first failing sample
interface nand2_check_if;
    logic       start;
    logic       A;
    logic       B;
    logic       Y;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic       mismatch;
    logic [2:0] err_cnt;
    logic [3:0] seen;
    logic [1:0] first_fail;

    modport master (
        output start, A, B, Y,
        input  busy, done, pass, timeout, mismatch, err_cnt, seen, first_fail
    );

    modport slave (
        input  start, A, B, Y,
        output busy, done, pass, timeout, mismatch, err_cnt, seen, first_fail
    );
endinterface

// File: rtl/nand2_check.sv
// nand2_check: self-checking response monitor for a 2-input NAND gate.
// Waits for {A,B} to stay stable for SETTLE edges, compares Y against the
// NAND truth table, tracks coverage of the four input vectors and gives a
// pass/fail verdict once all four are seen or the run timer expires.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (returns to IDLE, all outputs 0)
//   bus : nand2_check_if slave modport (start/A/B/Y in, status out)
module nand2_check #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         rst,
    nand2_check_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0]  STAB_LAST = 8'(SETTLE - 1);
    localparam logic [15:0] TMR_LAST  = 16'(TIMEOUT - 1);

    function automatic logic nand_ref(input logic a, input logic b);
        return ~(a & b);
    endfunction

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        logic [2:0] r;
        if (v == 3'd7) begin
            r = 3'd7;
        end else begin
            r = v + 3'd1;
        end
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  ab_s, prev_ab_r;
    logic [7:0]  stab_r, stab_s;
    logic [15:0] tmr_r, tmr_s;
    logic [2:0]  err_r, err_s;
    logic [3:0]  seen_r, seen_s;
    logic [1:0]  ff_r, ff_s;
    logic        to_r, to_s;
    logic        pass_r, pass_s;
    logic        mis_r, mis_s;
    logic        busy_r, done_r;
    logic        fail_s, sample_s;

    assign ab_s   = {bus.A, bus.B};
    // Case-inequality so that an X or Z on Y is a failure, not a pass.
    assign fail_s = (bus.Y !== nand_ref(bus.A, bus.B));

    // Next-state, sampling and verdict logic
    always_comb begin
        state_s  = state_r;
        stab_s   = stab_r;
        tmr_s    = tmr_r;
        err_s    = err_r;
        seen_s   = seen_r;
        ff_s     = ff_r;
        to_s     = to_r;
        pass_s   = pass_r;
        mis_s    = 1'b0;
        sample_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_s = ST_SETTLE;
                    stab_s  = 8'd0;
                    tmr_s   = 16'd0;
                    err_s   = 3'd0;
                    seen_s  = 4'd0;
                    ff_s    = 2'd0;
                    to_s    = 1'b0;
                    pass_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETTLE: begin
                tmr_s = tmr_r + 16'd1;
                if (ab_s != prev_ab_r) begin
                    stab_s  = 8'd0;
                    state_s = ST_SETTLE;
                end else if (stab_r == STAB_LAST) begin
                    sample_s = 1'b1;
                    state_s  = ST_HOLD;
                    seen_s   = seen_r | (4'b0001 << ab_s);
                    if (fail_s) begin
                        mis_s = 1'b1;
                        err_s = sat_inc3(err_r);
                        // err_cnt never returns to 0 within a run, so 0 marks the first miss
                        if (err_r == 3'd0) begin
                            ff_s = ab_s;
                        end else begin
                            ff_s = ff_r;
                        end
                    end else begin
                        err_s = err_r;
                    end
                end else begin
                    stab_s  = stab_r + 8'd1;
                    state_s = ST_SETTLE;
                end
                // A completing sample beats a simultaneous timeout.
                if (sample_s && (seen_s == 4'b1111)) begin
                    state_s = ST_DONE;
                    to_s    = 1'b0;
                    pass_s  = (err_s == 3'd0);
                end else if (tmr_r == TMR_LAST) begin
                    state_s = ST_DONE;
                    to_s    = 1'b1;
                    pass_s  = 1'b0;
                end else begin
                    to_s = to_r;
                end
            end
            ST_HOLD: begin
                tmr_s = tmr_r + 16'd1;
                if (tmr_r == TMR_LAST) begin
                    state_s = ST_DONE;
                    to_s    = 1'b1;
                    pass_s  = 1'b0;
                end else if (ab_s != prev_ab_r) begin
                    stab_s  = 8'd0;
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered status outputs; prev_ab follows {A,B} on every edge
    always_ff @(posedge clk) begin
        prev_ab_r <= ab_s;
        if (rst) begin
            state_r <= ST_IDLE;
            stab_r  <= 8'd0;
            tmr_r   <= 16'd0;
            err_r   <= 3'd0;
            seen_r  <= 4'd0;
            ff_r    <= 2'd0;
            to_r    <= 1'b0;
            pass_r  <= 1'b0;
            mis_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            stab_r  <= stab_s;
            tmr_r   <= tmr_s;
            err_r   <= err_s;
            seen_r  <= seen_s;
            ff_r    <= ff_s;
            to_r    <= to_s;
            pass_r  <= pass_s;
            mis_r   <= mis_s;
            busy_r  <= (state_s == ST_SETTLE) || (state_s == ST_HOLD);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.pass       = pass_r;
    assign bus.timeout    = to_r;
    assign bus.mismatch   = mis_r;
    assign bus.err_cnt    = err_r;
    assign bus.seen       = seen_r;
    assign bus.first_fail = ff_r;

endmodule

// File: tb/tb_nand2_check.sv
// tb_nand2_check: drives two nand2_check instances (SETTLE=2/TIMEOUT=1000 and
// SETTLE=3/TIMEOUT=50) with the same stimulus. A reference model per instance
// predicts each run verdict from stable-stretch lengths and run age, pushes it
// into a queue, and a monitor pops and compares whenever done rises.
module tb_nand2_check;

    typedef struct {
        int edge_no;
        int pass;
        int tout;
        int errs;
        int seen;
        int first;
        int mis;
    } exp_t;

    localparam int F_BUSY = 13, F_DONE = 12, F_PASS = 11, F_TOUT = 10;
    localparam int F_ERR = 6, F_SEEN = 2, F_FIRST = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, start_s, a_s, b_s, y_s;
    int   mode_s;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   end_req = 1'b0;
    logic [13:0] stat_w [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int fld(input int g, input int lsb, input int w);
        logic [13:0] s;
        s = stat_w[g] >> lsb;
        return int'(s & ((14'd1 << w) - 14'd1));
    endfunction

    function automatic logic y_for(input int mode, input logic [1:0] ab);
        logic r;
        case (mode)
            0:       r = ~(ab[1] & ab[0]);
            1:       r = ab[1] & ab[0];
            2:       r = 1'b1;
            default: r = 1'($urandom_range(0, 1));
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : 3;
        localparam int T = (g == 0) ? 1000 : 50;

        nand2_check_if bus ();
        exp_t q[$];
        int edge_no = 0;

        assign bus.start = start_s;
        assign bus.A     = a_s;
        assign bus.B     = b_s;
        assign bus.Y     = y_s;
        assign stat_w[g] = {bus.busy, bus.done, bus.pass, bus.timeout, bus.mismatch,
                            bus.err_cnt, bus.seen, bus.first_fail};

        nand2_check #(.SETTLE(S), .TIMEOUT(T)) dut (
            .clk (clk),
            .rst (rst_s),
            .bus (bus)
        );

        // Reference: a vector is sampled once it has been held for S+1 edges
        // (counting from the run start at most); the run ends on full coverage
        // or T edges after start.
        initial begin : model
            bit active, smp, complete;
            int t0, st, errs, mis;
            logic [3:0] seen;
            logic [1:0] first, ab, prev_ab;
            exp_t e;
            active = 0; smp = 0; t0 = 0; st = 0; errs = 0; mis = 0;
            seen = 4'd0; first = 2'd0; prev_ab = 2'd0;
            forever begin
                @(posedge clk);
                ab = {a_s, b_s};
                edge_no++;
                complete = 0;
                if (rst_s) begin
                    active = 0;
                end else if (!active) begin
                    if (start_s) begin
                        active = 1; t0 = edge_no; st = edge_no; smp = 0;
                        seen = 4'd0; errs = 0; mis = 0; first = 2'd0;
                    end
                end else begin
                    if (ab != prev_ab) begin
                        st = edge_no;
                        smp = 0;
                    end
                    if (!smp && (edge_no - st) == S) begin
                        smp = 1;
                        seen[ab] = 1'b1;
                        if (y_s !== ~(a_s & b_s)) begin
                            if (errs == 0) first = ab;
                            mis++;
                            if (errs < 7) errs++;
                        end
                        complete = (seen == 4'hF);
                    end
                    if (complete || (edge_no - t0) == T) begin
                        e.edge_no = edge_no;
                        e.tout    = complete ? 0 : 1;
                        e.pass    = (errs == 0 && complete) ? 1 : 0;
                        e.errs    = errs;
                        e.seen    = int'(seen);
                        e.first   = int'(first);
                        e.mis     = mis;
                        q.push_back(e);
                        active = 0;
                    end
                end
                prev_ab = ab;
            end
        end

        initial begin : monitor
            logic done_prev;
            int mis_seen;
            exp_t e;
            done_prev = 1'b0;
            mis_seen = 0;
            forever begin
                @(posedge clk);
                #1;
                if (rst_s) begin
                    mis_seen = 0;
                end else begin
                    if (bus.mismatch) mis_seen++;
                    if (bus.done && !done_prev) begin
                        if (q.size() == 0) begin
                            check($sformatf("dut%0d.unexpected_done", g), 1, 0);
                        end else begin
                            e = q.pop_front();
                            check($sformatf("dut%0d.done_edge", g), edge_no, e.edge_no);
                            check($sformatf("dut%0d.pass", g), int'(bus.pass), e.pass);
                            check($sformatf("dut%0d.timeout", g), int'(bus.timeout), e.tout);
                            check($sformatf("dut%0d.err_cnt", g), int'(bus.err_cnt), e.errs);
                            check($sformatf("dut%0d.seen", g), int'(bus.seen), e.seen);
                            check($sformatf("dut%0d.first_fail", g), int'(bus.first_fail), e.first);
                            check($sformatf("dut%0d.mismatch_pulses", g), mis_seen, e.mis);
                        end
                        mis_seen = 0;
                    end
                end
                done_prev = bus.done;
            end
        end

        initial begin : drain
            wait (end_req);
            check($sformatf("dut%0d.pending_verdicts", g), q.size(), 0);
        end
    end

    task automatic do_start();
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
    endtask

    task automatic hold(input logic [1:0] ab, input int n, input bit st);
        @(negedge clk);
        a_s = ab[1];
        b_s = ab[0];
        y_s = y_for(mode_s, ab);
        start_s = st;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            start_s = 1'b0;
        end
    endtask

    task automatic all_four(input int n);
        hold(2'b00, n, 1'b0);
        hold(2'b01, n, 1'b0);
        hold(2'b10, n, 1'b0);
        hold(2'b11, n, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(stat_w[0][F_DONE] && stat_w[1][F_DONE]) && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".done_in_time"}, int'(stat_w[0][F_DONE] && stat_w[1][F_DONE]), 1);
    endtask

    initial begin
        int start_edge, n;
        logic [1:0] v;
        bit st;
        rst_s = 1'b1; start_s = 1'b0; a_s = 1'b0; b_s = 1'b0; y_s = 1'b1; mode_s = 0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("reset.dut%0d.outputs", g), int'(stat_w[g]), 0);
        rst_s = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("idle.dut%0d.busy", g), fld(g, F_BUSY, 1), 0);

        // Ideal NAND, with done timing on the SETTLE=2 instance
        mode_s = 0;
        do_start();
        hold(2'b00, 10, 1'b0);
        hold(2'b01, 10, 1'b0);
        hold(2'b10, 10, 1'b0);
        @(negedge clk);
        a_s = 1'b1; b_s = 1'b1; y_s = y_for(mode_s, 2'b11);
        @(negedge clk);
        check("ideal.dut0.done_k", fld(0, F_DONE, 1), 0);
        @(negedge clk);
        check("ideal.dut0.done_k1", fld(0, F_DONE, 1), 0);
        @(negedge clk);
        check("ideal.dut0.done_k2", fld(0, F_DONE, 1), 1);
        repeat (7) @(negedge clk);
        wait_done("ideal");
        for (int g = 0; g < 2; g++) begin
            check($sformatf("ideal.dut%0d.pass", g), fld(g, F_PASS, 1), 1);
            check($sformatf("ideal.dut%0d.err", g), fld(g, F_ERR, 3), 0);
            check($sformatf("ideal.dut%0d.seen", g), fld(g, F_SEEN, 4), 15);
        end

        // AND gate in place of NAND
        mode_s = 1;
        do_start();
        all_four(10);
        wait_done("and");
        for (int g = 0; g < 2; g++) begin
            check($sformatf("and.dut%0d.err", g), fld(g, F_ERR, 3), 4);
            check($sformatf("and.dut%0d.first", g), fld(g, F_FIRST, 2), 0);
            check($sformatf("and.dut%0d.pass", g), fld(g, F_PASS, 1), 0);
        end

        // Y stuck at 1
        mode_s = 2;
        do_start();
        all_four(10);
        wait_done("stuck1");
        for (int g = 0; g < 2; g++) begin
            check($sformatf("stuck1.dut%0d.err", g), fld(g, F_ERR, 3), 1);
            check($sformatf("stuck1.dut%0d.first", g), fld(g, F_FIRST, 2), 3);
            check($sformatf("stuck1.dut%0d.seen", g), fld(g, F_SEEN, 4), 15);
            check($sformatf("stuck1.dut%0d.pass", g), fld(g, F_PASS, 1), 0);
        end

        // Short excursion to 10 is never sampled; then reset in HOLD
        mode_s = 0;
        do_start();
        hold(2'b00, 6, 1'b0);
        hold(2'b10, 2, 1'b0);
        hold(2'b01, 6, 1'b0);
        for (int g = 0; g < 2; g++) check($sformatf("glitch.dut%0d.seen", g), fld(g, F_SEEN, 4), 3);
        @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        for (int g = 0; g < 2; g++) check($sformatf("midrst.dut%0d.outputs", g), int'(stat_w[g]), 0);
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("midrst.dut%0d.stays_idle", g), int'(stat_w[g]), 0);

        // Saturation: failing samples alternating 00 / 11
        mode_s = 1;
        do_start();
        for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 2'b00 : 2'b11, 4, 1'b0);
        for (int g = 0; g < 2; g++) check($sformatf("sat.dut%0d.err", g), fld(g, F_ERR, 3), 7);
        wait_done("sat");

        // Restart from DONE, then timeout on the TIMEOUT=50 instance
        mode_s = 0;
        do_start();
        start_edge = cyc;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("restart.dut%0d.busy", g), fld(g, F_BUSY, 1), 1);
            check($sformatf("restart.dut%0d.err", g), fld(g, F_ERR, 3), 0);
            check($sformatf("restart.dut%0d.seen", g), fld(g, F_SEEN, 4), 0);
        end
        hold(2'b00, 8, 1'b0);
        hold(2'b01, 8, 1'b0);
        hold(2'b10, 8, 1'b0);
        n = 0;
        while (!stat_w[1][F_DONE] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo.dut1.done_cycle", cyc - start_edge, 50);
        check("tmo.dut1.timeout", fld(1, F_TOUT, 1), 1);
        check("tmo.dut1.pass", fld(1, F_PASS, 1), 0);
        check("tmo.dut1.seen", fld(1, F_SEEN, 4), 7);
        wait_done("tmo");
        check("tmo.dut0.timeout", fld(0, F_TOUT, 1), 1);

        // Randomized runs checked by the scoreboard
        for (int r = 0; r < 6; r++) begin
            mode_s = int'($urandom_range(0, 3));
            do_start();
            for (int s = 0; s < 8; s++) begin
                v = 2'($urandom_range(0, 3));
                st = ($urandom_range(0, 7) == 0);
                hold(v, int'($urandom_range(1, 6)), st);
            end
            all_four(5);
            wait_done($sformatf("rand%0d", r));
        end

        repeat (3) @(negedge clk);
        end_req = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
